// File: rtl/riscv_arb_pkg.sv
// Shared types and limits for the unified-memory arbiter.
// Owner tags steer in-order read data back to fetch or data port.
package riscv_arb_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_IF   = 2'd1,
      OWN_D    = 2'd2
   } owner_e;

   localparam int MEM_LAT_MAX = 4;
   localparam int STREAK_W    = 4;

endpackage

// File: rtl/riscv_arb_tag_pipe.sv
// Owner-tag delay line matching the memory read latency.
// Cleared asynchronously so in-flight responses vanish on reset.
module riscv_arb_tag_pipe
   import riscv_arb_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] tag_in,
   output logic [1:0] tag_out
);

   owner_e stage_q [MEM_LAT];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MEM_LAT; i++) begin
            stage_q[i] <= OWN_NONE;
         end
      end else begin
         stage_q[0] <= owner_e'(tag_in);
         for (int i = 1; i < MEM_LAT; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_out = stage_q[MEM_LAT-1];

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Fetch/load-store arbiter for one single-port fixed-latency memory.
// Define RISCV_ARB_PERF_EN to add saturating grant/conflict counters.
module riscv_mem_arbiter
   import riscv_arb_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int MEM_LAT    = 1,
   parameter int MAX_STREAK = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef RISCV_ARB_PERF_EN
  ,output logic [31:0]       perf_if_cnt,
   output logic [31:0]       perf_d_cnt,
   output logic [31:0]       perf_conflict_cnt
`endif
);

   if (MEM_LAT < 1 || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
      $fatal(1, "riscv_mem_arbiter: MEM_LAT out of range");
   end
   if (MAX_STREAK < 1 || MAX_STREAK > 15) begin : g_bad_streak
      $fatal(1, "riscv_mem_arbiter: MAX_STREAK out of range");
   end

   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

   logic [STREAK_W-1:0] streak_q;
   logic [STREAK_W-1:0] streak_d;
   logic [1:0]          tag_in;
   logic [1:0]          tag_out;

   // Data wins ties until fetch has watched MAX_STREAK data grants.
   always_comb begin
      if_gnt = 1'b0;
      d_gnt  = 1'b0;
      case ({if_req, d_req})
         2'b10: if_gnt = 1'b1;
         2'b01: d_gnt  = 1'b1;
         2'b11: begin
            if (streak_q == STREAK_MAX) begin
               if_gnt = 1'b1;
            end else begin
               d_gnt = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      streak_d = streak_q;
      if (!if_req || if_gnt) begin
         streak_d = '0;
      end else if (d_gnt && streak_q != STREAK_MAX) begin
         streak_d = streak_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end

   always_comb begin
      mem_en    = if_gnt | d_gnt;
      mem_we    = d_gnt & d_we;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_addr = if_addr;
      end else if (d_gnt) begin
         mem_addr  = d_addr;
         mem_wdata = d_wdata;
      end
   end

   always_comb begin
      tag_in = OWN_NONE;
      if (if_gnt) begin
         tag_in = OWN_IF;
      end else if (d_gnt && !d_we) begin
         tag_in = OWN_D;
      end
   end

   riscv_arb_tag_pipe #(
      .MEM_LAT (MEM_LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   assign if_rvalid = (tag_out == OWN_IF);
   assign d_rvalid  = (tag_out == OWN_D);
   assign if_rdata  = mem_rdata;
   assign d_rdata   = mem_rdata;

`ifdef RISCV_ARB_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_if_cnt       <= '0;
         perf_d_cnt        <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (if_gnt && perf_if_cnt != 32'hFFFF_FFFF) begin
            perf_if_cnt <= perf_if_cnt + 32'd1;
         end
         if (d_gnt && perf_d_cnt != 32'hFFFF_FFFF) begin
            perf_d_cnt <= perf_d_cnt + 32'd1;
         end
         if (if_req && d_req && perf_conflict_cnt != 32'hFFFF_FFFF) begin
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
